// File: rtl/laser_frame_scheduler.sv
// Two-laser frame scheduler for the two-colour miniscope.
// Synchronises camera V_SYNC, assigns each accepted frame to a laser and
// drives that laser's SYNC output for ON_TIME cycles after DELAY cycles.
module laser_frame_scheduler #(
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FCNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              V_SYNC,
  input  logic              ENABLE,
  input  logic [1:0]        MODE,
  input  logic [CNT_W-1:0]  DELAY,
  input  logic [CNT_W-1:0]  ON_TIME,
  output logic              SYNC_0,
  output logic              SYNC_1,
  output logic              FRAME_TAG,
  output logic [FCNT_W-1:0] FRAME_CNT,
  output logic              BUSY,
  output logic              OVERRUN
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_ON    = 2'd2
  } state_t;

  state_t                r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                  r_sync_d;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_on_sh;
  logic                  r_sel_sh;

  logic w_fs;
  logic w_accept;
  logic w_new_tag;
  logic w_null;
  logic w_sel;

  // V_SYNC synchroniser chain plus edge-detect flop
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], V_SYNC};
      r_sync_d <= r_sync[SYNC_STAGES-1];
    end
  end

  // Frame-start pulse and per-frame laser selection
  always_comb begin
    w_fs      = r_sync[SYNC_STAGES-1] & ~r_sync_d;
    w_accept  = w_fs & ENABLE;
    w_new_tag = ~FRAME_TAG;
    w_null    = (MODE == 2'd3) || (ON_TIME == '0);
    // mode 1 -> laser 0, mode 2 -> laser 1, mode 0 -> follows the new tag
    w_sel     = (MODE == 2'd0) ? w_new_tag : MODE[1];
  end

  // Scheduler FSM with registered laser, tag, count, busy and overrun outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_on_sh   <= '0;
      r_sel_sh  <= 1'b0;
      SYNC_0    <= 1'b0;
      SYNC_1    <= 1'b0;
      FRAME_TAG <= 1'b1;
      FRAME_CNT <= '0;
      BUSY      <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      OVERRUN <= 1'b0;
      if (!ENABLE) begin
        r_state <= S_IDLE;
        SYNC_0  <= 1'b0;
        SYNC_1  <= 1'b0;
        BUSY    <= 1'b0;
      end else if (w_accept) begin
        FRAME_TAG <= w_new_tag;
        FRAME_CNT <= FRAME_CNT + FCNT_W'(1);
        r_on_sh   <= ON_TIME;
        r_sel_sh  <= w_sel;
        SYNC_0    <= 1'b0;
        SYNC_1    <= 1'b0;
        if (w_null) begin
          r_state <= S_IDLE;
          BUSY    <= 1'b0;
          OVERRUN <= (r_state != S_IDLE);
        end else if (r_state != S_IDLE) begin
          // Abort: one forced both-low cycle, then the full new delay,
          // so the counter is loaded with DELAY rather than DELAY-1.
          OVERRUN <= 1'b1;
          r_state <= S_DELAY;
          r_cnt   <= DELAY;
          BUSY    <= 1'b1;
        end else if (DELAY != '0) begin
          r_state <= S_DELAY;
          r_cnt   <= DELAY - CNT_W'(1);
          BUSY    <= 1'b1;
        end else begin
          r_state <= S_ON;
          r_cnt   <= ON_TIME - CNT_W'(1);
          SYNC_0  <= ~w_sel;
          SYNC_1  <= w_sel;
          BUSY    <= 1'b1;
        end
      end else begin
        case (r_state)
          S_DELAY: begin
            if (r_cnt == '0) begin
              r_state <= S_ON;
              r_cnt   <= r_on_sh - CNT_W'(1);
              SYNC_0  <= ~r_sel_sh;
              SYNC_1  <= r_sel_sh;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          S_ON: begin
            if (r_cnt == '0) begin
              r_state <= S_IDLE;
              SYNC_0  <= 1'b0;
              SYNC_1  <= 1'b0;
              BUSY    <= 1'b0;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_laser_frame_scheduler.sv
// Randomised self-checking bench for laser_frame_scheduler, using a
// window-based reference model (per-frame pulse/busy intervals in cycles).
module tb_laser_frame_scheduler;

  localparam int unsigned CW = 24;
  localparam int unsigned FW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          V_SYNC = 1'b0;
  logic          ENABLE = 1'b0;
  logic [1:0]    MODE = 2'd0;
  logic [CW-1:0] DELAY = '0;
  logic [CW-1:0] ON_TIME = '0;
  logic          SYNC_0, SYNC_1, FRAME_TAG, BUSY, OVERRUN;
  logic [FW-1:0] FRAME_CNT;

  laser_frame_scheduler #(.CNT_W(CW), .SYNC_STAGES(2), .FCNT_W(FW)) dut (
    .CLK(CLK), .RST(RST), .V_SYNC(V_SYNC), .ENABLE(ENABLE), .MODE(MODE),
    .DELAY(DELAY), .ON_TIME(ON_TIME), .SYNC_0(SYNC_0), .SYNC_1(SYNC_1),
    .FRAME_TAG(FRAME_TAG), .FRAME_CNT(FRAME_CNT), .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  int     n_checks = 0;
  int     n_fail = 0;
  longint cyc = 0;
  longint acc_q[$];

  // reference model state: intervals are inclusive cycle ranges
  longint m_win_lo = 1, m_win_hi = 0, m_busy_lo = 1, m_busy_hi = 0, m_ovr = -1;
  int     m_laser = 0;
  logic   m_tag = 1'b1;
  int     m_cnt = 0;

  int hi0 = 0, hi1 = 0, n_ovr = 0, n_busy = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint lmin(input longint a, input longint b);
    return (a < b) ? a : b;
  endfunction

  // model update at every active edge
  always @(posedge CLK) begin
    bit acc;
    bit ovr;
    cyc++;
    acc = (acc_q.size() > 0) && (acc_q[0] == cyc);
    if (acc) void'(acc_q.pop_front());
    if (RST) begin
      m_win_lo = 1; m_win_hi = 0; m_busy_lo = 1; m_busy_hi = 0; m_ovr = -1;
      m_tag = 1'b1; m_cnt = 0;
    end else if (!ENABLE) begin
      m_win_hi  = lmin(m_win_hi, cyc - 1);
      m_busy_hi = lmin(m_busy_hi, cyc - 1);
    end else if (acc) begin
      ovr = (m_busy_lo <= cyc - 1) && (cyc - 1 <= m_busy_hi);
      if (ovr) m_ovr = cyc;
      m_tag = ~m_tag;
      m_cnt = (m_cnt + 1) % (1 << FW);
      m_laser = (MODE == 2'd0) ? int'(m_tag) : ((MODE == 2'd1) ? 0 : 1);
      if (MODE == 2'd3 || ON_TIME == 0) begin
        m_win_lo = 1; m_win_hi = 0; m_busy_lo = 1; m_busy_hi = 0;
      end else begin
        m_win_lo  = cyc + longint'(DELAY) + (ovr ? 1 : 0);
        m_win_hi  = m_win_lo + longint'(ON_TIME) - 1;
        m_busy_lo = cyc;
        m_busy_hi = m_win_hi;
      end
    end
  end

  // compare outputs mid-cycle
  always @(negedge CLK) begin
    if (cyc >= 1) begin
      bit in_win;
      in_win = (cyc >= m_win_lo) && (cyc <= m_win_hi);
      check("sync0", {31'd0, SYNC_0}, {31'd0, in_win && m_laser == 0});
      check("sync1", {31'd0, SYNC_1}, {31'd0, in_win && m_laser == 1});
      check("busy", {31'd0, BUSY}, {31'd0, (cyc >= m_busy_lo) && (cyc <= m_busy_hi)});
      check("overrun", {31'd0, OVERRUN}, {31'd0, cyc == m_ovr});
      check("tag", {31'd0, FRAME_TAG}, {31'd0, m_tag});
      check("fcnt", {24'd0, FRAME_CNT}, m_cnt);
      check("interlock", {31'd0, SYNC_0 & SYNC_1}, 32'd0);
      hi0 += int'(SYNC_0 === 1'b1);
      hi1 += int'(SYNC_1 === 1'b1);
      n_ovr += int'(OVERRUN === 1'b1);
      n_busy += int'(BUSY === 1'b1);
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge CLK);
  endtask

  // one V_SYNC pulse (2 cycles high); accept lands 3 edges after the rise
  task automatic frame(input int unsigned gap);
    V_SYNC = 1'b1;
    acc_q.push_back(cyc + 3);
    tick(2);
    V_SYNC = 1'b0;
    tick(gap);
  endtask

  task automatic clr_counts();
    hi0 = 0; hi1 = 0; n_ovr = 0; n_busy = 0;
  endtask

  initial begin
    tick(3);
    RST = 1'b0;
    ENABLE = 1'b1;
    tick(2);

    // alternate mode, 4 frames 1000 cycles apart
    clr_counts();
    MODE = 2'd0; DELAY = 10; ON_TIME = 100;
    repeat (4) frame(998);
    check("t1_hi0", hi0, 200);
    check("t1_hi1", hi1, 200);
    check("t1_fcnt", {24'd0, FRAME_CNT}, 4);

    // fixed-laser modes, zero delay
    clr_counts();
    MODE = 2'd1; DELAY = 0; ON_TIME = 5;
    repeat (3) frame(20);
    MODE = 2'd2;
    repeat (3) frame(20);
    check("t2_hi0", hi0, 15);
    check("t2_hi1", hi1, 15);

    // overruns: frames faster than delay+on-time
    clr_counts();
    MODE = 2'd0; DELAY = 50; ON_TIME = 500;
    repeat (5) frame(198);
    tick(700);
    check("t3_ovr", n_ovr, 4);

    // dark frames
    clr_counts();
    ON_TIME = 0;
    repeat (2) frame(30);
    MODE = 2'd3; ON_TIME = 50;
    repeat (2) frame(30);
    check("t4_laser", hi0 + hi1, 0);
    check("t4_busy", n_busy, 0);

    // ENABLE drop mid-ON, then RST mid-DELAY
    MODE = 2'd0; DELAY = 10; ON_TIME = 100;
    frame(50);
    ENABLE = 1'b0;
    tick(20);
    ENABLE = 1'b1;
    tick(150);
    DELAY = 200; ON_TIME = 50;
    frame(20);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    tick(300);

    // frame counter wrap, then DELAY changed mid-frame
    MODE = 2'd3;
    repeat (260) frame(4);
    MODE = 2'd0; DELAY = 30; ON_TIME = 10;
    frame(5);
    DELAY = 3;
    tick(60);

    // randomised frames
    for (int i = 0; i < 40; i++) begin
      MODE    = 2'($urandom_range(0, 3));
      DELAY   = CW'($urandom_range(0, 60));
      ON_TIME = CW'($urandom_range(0, 150));
      if ($urandom_range(0, 7) == 0) ON_TIME = 0;
      frame($urandom_range(4, 80));
      if ($urandom_range(0, 5) == 0) begin
        ENABLE = 1'b0;
        tick($urandom_range(1, 20));
        ENABLE = 1'b1;
      end
      tick($urandom_range(0, 150));
    end
    tick(300);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
